imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Registered, multi-lane immediate generator with a valid/ready skid buffer and flush, parametrised for RV32/RV64 and 1–4 decode lanes. It sits between the decode-stage instruction register and the ID/EX pipeline register. It produces fully sign- or zero-extended immediates one cycle after acceptance, and absorbs one cycle of downstream backpressure without dropping data.

## Interface
- XLEN, 32, output immediate width; legal values 32 or 64
- LANES, 1, parallel decode lanes sharing one handshake; legal values 1–4
- clk_i  in  1  clock; all state updates on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous flush; clears all buffered entries
- in_valid_i  in  1  input bundle valid
- in_ready_o  out  1  block can accept a bundle this cycle
- instr_i  in  LANES×25  instruction bits [31:7] per lane
- imm_src_i  in  LANES×3  immediate type per lane
- out_valid_o  out  1  output bundle valid
- out_ready_i  in  1  downstream accepts the bundle this cycle
- imm_ext_o  out  LANES×XLEN  extended immediate per lane
- illegal_o  out  LANES  imm_src code 111 seen on that lane

## Operation
- Handshake: input transfer when in_valid_i && in_ready_o; output transfer when out_valid_o && out_ready_i. All lanes move together.
- Decode is combinational at the input; both buffer slots store already-extended values.
- imm_src encoding:
  - 000 I: instr[31:20] sign-extended
  - 001 S: {instr[31:25], instr[11:7]} sign-extended
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended
  - 100 U: {instr[31:12], 12'b0}, with bit 31 sign-extended to XLEN
  - 101 Zimm: instr[19:15] zero-extended (CSR immediate forms)
  - 110 shamt: instr[25:20] zero-extended when XLEN=64; instr[24:20] when XLEN=32
  - 111: output 0 and illegal_o=1 for that lane; otherwise illegal_o=0
- Storage is a main output register plus one skid register. State machine:
  - EMPTY: out_valid_o=0. On input transfer → ONE.
  - ONE: main register valid. If input transfers and output transfers → ONE, main loaded with the new data. If input transfers only → TWO, skid loaded. If output transfers only → EMPTY.
  - TWO: both registers valid; in_ready_o=0. On output transfer, skid moves to main → ONE.
- in_ready_o = (state != TWO). It depends only on registered state; there is no combinational path from out_ready_i.
- Ordering is strict FIFO; no bundle is ever dropped or duplicated.
- flush_i (highest priority): the next state is EMPTY. Any input bundle offered in the same cycle is discarded, and an output transfer in that cycle still counts downstream.

## Timing
- Latency is 1 cycle from input transfer to out_valid_o, when the block was EMPTY or draining.
- Throughput is 1 bundle per cycle while out_ready_i is high.
- Reset (rst_n_i low, applied asynchronously): state=EMPTY, out_valid_o=0, imm_ext_o=0, illegal_o=0, skid cleared. in_ready_o reads 1, but inputs are ignored while reset is held.
- Reset released mid-operation: all buffered bundles are lost and operation restarts from EMPTY.
- imm_ext_o and illegal_o hold their value while out_valid_o && !out_ready_i. Their contents are don't-care when out_valid_o=0, except immediately after reset, when they are 0.

## Structure
- Package imm_pkg holds:
  - the imm_src_e enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_ZIMM, IMM_SHAMT, IMM_ILLEGAL)
  - the state enum (EMPTY, ONE, TWO)
  - the instruction-field width constant (25)
- Sub-module imm_decode_lane: combinational, parametrised by XLEN, instantiated LANES times. The top level contains only the handshake FSM and the two registers.

## Test plan
- Reset: rst_n_i low mid-stream → out_valid_o=0, imm_ext_o=0 immediately. After release, in_ready_o=1 and state is EMPTY.
- I and B types (XLEN=32, LANES=2): lane0 instr=0xFFF00093>>7 with 000; lane1 instr=0xFE000EE3>>7 with 010. One cycle later → 0xFFFFFFFF and 0xFFFFFFFC.
- XLEN=64: U instr 0x800000B7 → 0xFFFFFFFF80000000. Zimm instr 0x0007D073 with 101 → 0x000000000000000F. Code 111 → 0 with illegal_o=1.
- Backpressure: out_ready_i=0 while pushing A, B, C → A and B accepted, in_ready_o=0 after B, C held. Raise out_ready_i → outputs A, B, C in order, one per cycle, no gaps.
- Flush in TWO with in_valid_i=1 → next cycle out_valid_o=0 and in_ready_o=1. Neither the buffered bundles nor the input offered during flush ever appear at the output.
- Random stress: 10k bundles with random valid/ready → output sequence equals a scoreboard of accepted inputs run through a reference decode.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate-extension pipeline: immediate formats,
// buffer occupancy states and the width of the instruction field it consumes.
package imm_pkg;

    // Instruction bits [31:7]; the opcode field never contributes to an immediate.
    localparam int INSTR_W = 25;

    typedef enum logic [2:0] {
        IMM_I       = 3'b000,
        IMM_S       = 3'b001,
        IMM_B       = 3'b010,
        IMM_J       = 3'b011,
        IMM_U       = 3'b100,
        IMM_ZIMM    = 3'b101,
        IMM_SHAMT   = 3'b110,
        IMM_ILLEGAL = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_e;

endpackage

// File: rtl/imm_decode_lane.sv
// Combinational immediate extraction and extension for one decode lane.
// Field indices are original instruction bit positions minus 7.
module imm_decode_lane
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    input  imm_src_e           imm_src,
    output logic [XLEN-1:0]    imm,
    output logic               illegal
);

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:    imm = {{(XLEN-12){instr[24]}}, instr[24:13]};
            IMM_S:    imm = {{(XLEN-12){instr[24]}}, instr[24:18], instr[4:0]};
            IMM_B:    imm = {{(XLEN-12){instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
            IMM_J:    imm = {{(XLEN-20){instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
            // Replicate bit 31 from position 31 upward so XLEN=32 needs no zero-width term.
            IMM_U:    imm = {{(XLEN-31){instr[24]}}, instr[23:5], 12'b0};
            IMM_ZIMM: imm = {{(XLEN-5){1'b0}}, instr[12:8]};
            IMM_SHAMT: begin
                if (XLEN == 64) imm = {{(XLEN-6){1'b0}}, instr[18:13]};
                else            imm = {{(XLEN-5){1'b0}}, instr[17:13]};
            end
            IMM_ILLEGAL: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Multi-lane immediate generator: per-lane decode feeding a two-entry
// main/skid output buffer with valid/ready handshake and synchronous flush.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [LANES-1:0][INSTR_W-1:0]  instr_i,
    input  logic [LANES-1:0][2:0]          imm_src_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [LANES-1:0][XLEN-1:0]     imm_ext_o,
    output logic [LANES-1:0]               illegal_o
);

    typedef struct packed {
        logic [LANES-1:0][XLEN-1:0] imm;
        logic [LANES-1:0]           ill;
    } bundle_t;

    logic [LANES-1:0][XLEN-1:0] dec_imm;
    logic [LANES-1:0]           dec_ill;
    bundle_t                    dec, main_q, skid_q;
    state_e                     state, state_nxt;
    logic                       in_xfer, out_xfer;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        imm_decode_lane #(.XLEN(XLEN)) u_dec (
            .instr   (instr_i[l]),
            .imm_src (imm_src_e'(imm_src_i[l])),
            .imm     (dec_imm[l]),
            .illegal (dec_ill[l])
        );
    end

    assign dec      = '{imm: dec_imm, ill: dec_ill};
    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_xfer) state_nxt = ONE;
                ONE: begin
                    if (in_xfer && !out_xfer)      state_nxt = TWO;
                    else if (!in_xfer && out_xfer) state_nxt = EMPTY;
                end
                TWO:     if (out_xfer) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Handshake outputs come from registered state only; no path from out_ready_i.
    always_comb begin
        out_valid_o = (state != EMPTY);
        in_ready_o  = (state != TWO);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            skid_q <= '0;
        end else begin
            if (state == TWO) begin
                if (out_xfer) main_q <= skid_q;
            end else if (in_xfer && (state == EMPTY || out_xfer)) begin
                main_q <= dec;
            end
            if (state == ONE && in_xfer && !out_xfer) skid_q <= dec;
        end
    end

    assign imm_ext_o = main_q.imm;
    assign illegal_o = main_q.ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Drives an RV32 and an RV64 two-lane instance with identical stimulus and
// compares both against a FIFO scoreboard plus an arithmetic immediate model.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    localparam int L = 2;

    typedef struct {
        logic [L-1:0][INSTR_W-1:0] f;
        logic [L-1:0][2:0]         s;
    } bun_t;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [L-1:0][INSTR_W-1:0] instr = '0;
    logic [L-1:0][2:0]         src = '0;
    logic                      rdy32, vld32, rdy64, vld64;
    logic [L-1:0][31:0]        imm32;
    logic [L-1:0][63:0]        imm64;
    logic [L-1:0]              ill32, ill64;
    int                        nchk = 0, nerr = 0, acc = 0, cyc = 0;
    bun_t                      q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .LANES(L)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy32), .instr_i(instr), .imm_src_i(src), .out_valid_o(vld32),
        .out_ready_i(out_ready), .imm_ext_o(imm32), .illegal_o(ill32)
    );

    imm_extend_pipe #(.XLEN(64), .LANES(L)) dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(rdy64), .instr_i(instr), .imm_src_i(src), .out_valid_o(vld64),
        .out_ready_i(out_ready), .imm_ext_o(imm64), .illegal_o(ill64)
    );

    // Rebuild the full instruction word and compute the immediate's numeric value.
    function automatic logic [63:0] ref_imm(input logic [24:0] f, input logic [2:0] s, input int xlen);
        logic [31:0] w;
        longint      v;
        w = {f, 7'b0};
        case (s)
            3'd0: begin v = longint'(w[31:20]); if (w[31]) v -= 64'sd4096; end
            3'd1: begin v = longint'({w[31:25], w[11:7]}); if (w[31]) v -= 64'sd4096; end
            3'd2: begin v = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}); if (w[31]) v -= 64'sd8192; end
            3'd3: begin v = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}); if (w[31]) v -= 64'sd2097152; end
            3'd4: begin v = longint'({w[31:12], 12'b0}); if (w[31]) v -= 64'sh1_0000_0000; end
            3'd5: v = longint'(w[19:15]);
            3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 0;
        endcase
        return (xlen == 32) ? {32'b0, v[31:0]} : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        chk("vld32", 64'(vld32), 64'(q.size() != 0));
        chk("vld64", 64'(vld64), 64'(q.size() != 0));
        chk("rdy32", 64'(rdy32), 64'(q.size() < 2));
        chk("rdy64", 64'(rdy64), 64'(q.size() < 2));
        if (q.size() != 0) begin
            for (int l = 0; l < L; l++) begin
                chk("imm32", 64'(imm32[l]), ref_imm(q[0].f[l], q[0].s[l], 32));
                chk("imm64", imm64[l], ref_imm(q[0].f[l], q[0].s[l], 64));
                chk("ill32", 64'(ill32[l]), 64'(q[0].s[l] == 3'd7));
                chk("ill64", 64'(ill64[l]), 64'(q[0].s[l] == 3'd7));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int l = 0; l < L; l++) begin
            chk({tag, "_imm32"}, 64'(imm32[l]), 64'd0);
            chk({tag, "_imm64"}, imm64[l], 64'd0);
            chk({tag, "_ill"}, 64'({ill32[l], ill64[l]}), 64'd0);
        end
    endtask

    task automatic rand_bundle();
        for (int l = 0; l < L; l++) begin
            instr[l] = 25'($urandom);
            src[l]   = 3'($urandom_range(0, 7));
        end
    endtask

    // One clock: check at the falling edge, then advance the scoreboard.
    task automatic step();
        logic ix, ox;
        @(negedge clk);
        check_outs();
        ix = rst_n && in_valid && (q.size() < 2);
        ox = rst_n && out_ready && (q.size() != 0);
        @(posedge clk);
        if (ox) void'(q.pop_front());
        if (flush) q.delete();
        else if (ix) q.push_back('{f: instr, s: src});
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset, with inputs offered that must be ignored.
        #3;
        chk_zero("rst");
        chk("rst_rdy", 64'({rdy32, rdy64}), 64'd3);
        rand_bundle();
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();

        // I and B types
        instr[0] = 25'(32'hFFF00093 >> 7); src[0] = 3'd0;
        instr[1] = 25'(32'hFE000EE3 >> 7); src[1] = 3'd2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ib_i", 64'(imm32[0]), 64'hFFFF_FFFF);
        chk("ib_b", 64'(imm32[1]), 64'hFFFF_FFFC);
        step();

        // U and Zimm, then illegal and shamt
        instr[0] = 25'(32'h800000B7 >> 7); src[0] = 3'd4;
        instr[1] = 25'(32'h0007D073 >> 7); src[1] = 3'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("u64", imm64[0], 64'hFFFF_FFFF_8000_0000);
        chk("u32", 64'(imm32[0]), 64'h8000_0000);
        chk("zimm64", imm64[1], 64'h0000_0000_0000_000F);
        step();
        instr[0] = 25'h1FF_FFFF;           src[0] = 3'd7;
        instr[1] = 25'(32'h03F01013 >> 7); src[1] = 3'd6;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ill_imm", imm64[0], 64'd0);
        chk("ill_flag", 64'({ill64, ill32}), 64'b0101);
        chk("shamt64", imm64[1], 64'd63);
        chk("shamt32", 64'(imm32[1]), 64'd31);
        step();

        // Backpressure: A and B accepted, C held until the buffer drains.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_bundle(); step();
        rand_bundle(); step();
        chk("bp_rdy", 64'(rdy32), 64'd0);
        rand_bundle(); step(); step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();

        // Flush while full with a bundle offered.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_bundle(); step();
        rand_bundle(); step();
        rand_bundle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_vld", 64'({vld32, vld64}), 64'd0);
        chk("fl_rdy", 64'({rdy32, rdy64}), 64'd3);
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_bundle(); step();
        rand_bundle(); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("mrst_vld", 64'({vld32, vld64}), 64'd0);
        chk_zero("mrst");
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Random stress.
        while (acc < 10000 && cyc < 60000) begin
            rand_bundle();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            if (in_valid && !flush && q.size() < 2) acc++;
            step();
            cyc++;
        end
        chk("stress_budget", 64'(acc >= 10000), 64'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
